spi_mem_master: RTL

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

---
 rtl/spi_mem_pkg.sv | 29 ++
 rtl/spi_clk_gen.sv | 40 ++++
 rtl/spi_mem_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants, state encoding and frame builder for the SPI memory master.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ         = 8'h03;
  localparam logic [7:0] OP_WRITE        = 8'h02;
  localparam int         CMD_BITS        = 8;
  localparam int         ADDR_PHASE_BITS = 24;
  localparam int         DATA_BITS       = 8;
  localparam int         FRAME_BITS      = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  // Full 40-bit frame, MSB first; the data byte is zero for reads so mosi idles low.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                       is_wr,
    input logic [ADDR_PHASE_BITS-1:0] addr,
    input logic [DATA_BITS-1:0]       wdata
  );
    build_frame = {(is_wr ? OP_WRITE : OP_READ), addr,
                   (is_wr ? wdata : {DATA_BITS{1'b0}})};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: toggles sclk every CLK_DIV clk cycles while run is high and
// provides strobes that are high in the cycle whose closing edge moves sclk.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_done;

  assign half_done = run && (cnt == CNT_MAX);
  assign rise_stb  = half_done && !sclk;
  assign fall_stb  = half_done && sclk;

  // Half-period counter and sclk toggle; idles low with the counter cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (half_done) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master issuing one 40-bit read/write frame per request:
// opcode, 24-bit address, one data byte. Followed by a short guard interval.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_EXT   = 20,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_we,
  input  logic                  spi_re,
  input  logic [ADDR_EXT-1:0]   spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_din,
  output logic [DATA_WIDTH-1:0] spi_dout,
  output logic                  spi_busy,
  output logic                  spi_done,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int               GCNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [GCNT_W-1:0] GCNT_MAX = GCNT_W'(CLK_DIV - 1);
  localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0]       CMD_LAST  = 6'(CMD_BITS - 1);
  localparam logic [5:0]       ADDR_LAST = 6'(CMD_BITS + ADDR_PHASE_BITS - 1);

  state_t                     state;
  logic [FRAME_BITS-2:0]      sh;        // bits still to be sent after the current one
  logic [5:0]                 bit_cnt;   // bits completed (counted on sclk falls)
  logic [GCNT_W-1:0]          g_cnt;
  logic [DATA_BITS-1:0]       rx;
  logic                       is_read;
  logic                       run;
  logic                       rise_stb;
  logic                       fall_stb;
  logic [ADDR_PHASE_BITS-1:0] addr24;
  logic [FRAME_BITS-1:0]      frame_load;

  assign addr24     = ADDR_PHASE_BITS'(spi_addr);
  assign frame_load = build_frame(spi_we, addr24, DATA_BITS'(spi_din));
  assign run        = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Frame sequencer: accept, shift out on sclk falls, sample on rises, guard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      g_cnt    <= '0;
      rx       <= '0;
      is_read  <= 1'b0;
      spi_dout <= '0;
      spi_busy <= 1'b0;
      spi_done <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spi_we || spi_re) begin
            // A simultaneous we/re is a write: spi_we alone selects the opcode.
            is_read  <= !spi_we;
            mosi     <= frame_load[FRAME_BITS-1];
            sh       <= frame_load[FRAME_BITS-2:0];
            bit_cnt  <= '0;
            cs_n     <= 1'b0;
            spi_busy <= 1'b1;
            state    <= ST_CMD;
          end
        end

        ST_CMD, ST_ADDR, ST_DATA: begin
          if (rise_stb && (state == ST_DATA)) begin
            rx <= {rx[DATA_BITS-2:0], miso};
          end
          if (fall_stb) begin
            if (bit_cnt == LAST_BIT) begin
              cs_n     <= 1'b1;
              mosi     <= 1'b0;
              spi_done <= 1'b1;
              if (is_read) begin
                spi_dout <= DATA_WIDTH'(rx);
              end
              g_cnt    <= '0;
              state    <= ST_GUARD;
            end else begin
              mosi    <= sh[FRAME_BITS-2];
              sh      <= {sh[FRAME_BITS-3:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CMD_LAST) begin
                state <= ST_ADDR;
              end else if (bit_cnt == ADDR_LAST) begin
                state <= ST_DATA;
              end
            end
          end
        end

        ST_GUARD: begin
          if (g_cnt == GCNT_MAX) begin
            spi_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            g_cnt <= g_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
